// File: rtl/legv8_multicycle_control_if.sv
// Shared instruction/data memory port between the LEGv8 sequencer and memory.
// The sequencer is the master: it issues requests, memory returns data and ready.
interface legv8_multicycle_control_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        control_iord;
  logic        control_memread;
  logic        control_memwrite;

  modport master (
    input  instruction, mem_ready,
    output control_iord, control_memread, control_memwrite
  );

  modport slave (
    output instruction, mem_ready,
    input  control_iord, control_memread, control_memwrite
  );
endinterface

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with a memory-wait timeout.
// Controls are decoded from the registered state and IR; FAULT is terminal until reset.
module legv8_multicycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  legv8_multicycle_control_if.master        mem,
  input  logic                              alu_zero_i,
  output logic [31:0]                       ir_o,
  output logic                              control_pcwrite_o,
  output logic                              control_pcsrc_o,
  output logic                              control_irwrite_o,
  output logic                              control_reg2loc_o,
  output logic                              control_alusrc_o,
  output logic [1:0]                        control_alu_op_o,
  output logic                              control_regwrite_o,
  output logic                              control_mem2reg_o,
  output logic                              fault_o,
  output logic [2:0]                        state_o
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     ir_q;
  logic [WW-1:0]   wait_q, wait_d;

  logic is_b, is_cbz, is_ldur, is_stur, is_rtype, is_legal;
  logic ir_load, timed_out;

  assign is_b     = (ir_q[31:26] == 6'b000101);
  assign is_cbz   = (ir_q[31:24] == 8'b10110100);
  assign is_ldur  = (ir_q[31:21] == 11'b11111000010);
  assign is_stur  = (ir_q[31:21] == 11'b11111000000);
  assign is_rtype = (ir_q[31:21] == 11'b10001011000) || (ir_q[31:21] == 11'b11001011000) ||
                    (ir_q[31:21] == 11'b10001010000) || (ir_q[31:21] == 11'b10101010000);
  assign is_legal = is_b | is_cbz | is_ldur | is_stur | is_rtype;

  // wait_q counts earlier unready cycles, so it equals TIMEOUT-1 in the TIMEOUT-th cycle
  assign timed_out = (wait_q == WAIT_LAST);
  assign ir_load   = (state_q == S_FETCH) && mem.mem_ready;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (mem.mem_ready)  state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
        else                wait_d  = wait_q + WW'(1);
      end
      S_DECODE: state_d = is_legal ? S_EXEC : S_FAULT;
      S_EXEC: begin
        if (is_rtype)               state_d = S_WB;
        else if (is_ldur || is_stur) state_d = S_MEM;
        else                        state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem.mem_ready)  state_d = is_ldur ? S_WB : S_FETCH;
        else if (timed_out) state_d = S_FAULT;
        else                wait_d  = wait_q + WW'(1);
      end
      S_WB:    state_d = S_FETCH;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (ir_load) ir_q <= mem.instruction;
    end
  end

  // Decoded combinationally and masked by rst so an in-flight write drops the moment reset rises
  always_comb begin
    control_pcwrite_o    = 1'b0;
    control_pcsrc_o      = 1'b0;
    control_irwrite_o    = 1'b0;
    control_reg2loc_o    = 1'b0;
    control_alusrc_o     = 1'b0;
    control_alu_op_o     = 2'b00;
    control_regwrite_o   = 1'b0;
    control_mem2reg_o    = 1'b0;
    mem.control_iord     = 1'b0;
    mem.control_memread  = 1'b0;
    mem.control_memwrite = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem.control_memread = 1'b1;
          control_irwrite_o   = mem.mem_ready;
          control_pcwrite_o   = mem.mem_ready;
        end
        S_EXEC: begin
          if (is_rtype) begin
            control_alu_op_o = 2'b10;
          end else if (is_ldur) begin
            control_alusrc_o = 1'b1;
          end else if (is_stur) begin
            control_alusrc_o  = 1'b1;
            control_reg2loc_o = 1'b1;
          end else if (is_b) begin
            control_pcwrite_o = 1'b1;
            control_pcsrc_o   = 1'b1;
          end else if (is_cbz) begin
            control_reg2loc_o = 1'b1;
            control_alu_op_o  = 2'b01;
            control_pcsrc_o   = 1'b1;
            control_pcwrite_o = alu_zero_i;
          end
        end
        S_MEM: begin
          mem.control_iord     = 1'b1;
          control_alusrc_o     = 1'b1;
          mem.control_memread  = is_ldur;
          mem.control_memwrite = is_stur;
          control_reg2loc_o    = is_stur;
        end
        S_WB: begin
          control_regwrite_o = 1'b1;
          control_mem2reg_o  = is_ldur;
        end
        default: ;
      endcase
    end
  end

  assign ir_o    = ir_q;
  assign fault_o = (state_q == S_FAULT);
  assign state_o = state_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for the LEGv8 multi-cycle sequencer: per-cycle state and control-word tables.
module tb_legv8_multicycle_control;

  localparam logic [31:0] I_ADD  = 32'h8B020065;
  localparam logic [31:0] I_LDUR = 32'hF8400142;
  localparam logic [31:0] I_STUR = 32'hF80010E4;
  localparam logic [31:0] I_CBZ  = 32'hB4000041;
  localparam logic [31:0] I_B    = 32'h14000003;

  logic        clk;
  logic        rst;
  logic        alu_zero;
  logic [31:0] ir;
  logic        pcwrite, pcsrc, irwrite, reg2loc, alusrc, regwrite, mem2reg, fault;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [11:0] ctl;

  int n_cmp  = 0;
  int n_fail = 0;

  legv8_multicycle_control_if mif ();

  legv8_multicycle_control #(.TIMEOUT(15)) dut (
    .clk                (clk),
    .rst                (rst),
    .mem                (mif),
    .alu_zero_i         (alu_zero),
    .ir_o               (ir),
    .control_pcwrite_o  (pcwrite),
    .control_pcsrc_o    (pcsrc),
    .control_irwrite_o  (irwrite),
    .control_reg2loc_o  (reg2loc),
    .control_alusrc_o   (alusrc),
    .control_alu_op_o   (alu_op),
    .control_regwrite_o (regwrite),
    .control_mem2reg_o  (mem2reg),
    .fault_o            (fault),
    .state_o            (state)
  );

  // {pcwrite,pcsrc,irwrite,iord,memread,memwrite,reg2loc,alusrc,alu_op[1:0],regwrite,mem2reg}
  assign ctl = {pcwrite, pcsrc, irwrite, mif.control_iord, mif.control_memread,
                mif.control_memwrite, reg2loc, alusrc, alu_op, regwrite, mem2reg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench 1 time unit after a posedge, with reset released: cycle 1 of FETCH.
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; mif.mem_ready = 1'b0; mif.instruction = I_ADD;
    #2;
    n_cmp++;
    if (state !== 3'd0 || ctl !== 12'h000 || fault !== 1'b0 || ir !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_held state=%0d ctl=%h fault=%b ir=%h, want 0/000/0/0", state, ctl, fault, ir);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_cmp++;
    if (state !== 3'd0 || ctl !== 12'h080) begin
      n_fail++;
      $display("FAIL reset_release state=%0d ctl=%h, want 0/080", state, ctl);
    end
  endtask

  task automatic test_add();
    logic        rdy [5];
    logic [2:0]  st  [5];
    logic [11:0] cv  [5];
    rdy = '{1, 1, 1, 1, 0};
    st  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    cv  = '{12'hA80, 12'h000, 12'h008, 12'h002, 12'h080};
    mif.instruction = I_ADD; alu_zero = 1'b0;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      mif.mem_ready = rdy[c]; #1;
      n_cmp++;
      if (state !== st[c] || ctl !== cv[c]) begin
        n_fail++;
        $display("FAIL add cyc%0d state=%0d ctl=%h, want %0d/%h", c + 1, state, ctl, st[c], cv[c]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ir !== I_ADD || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL add_ir ir=%h fault=%b, want %h/0", ir, fault, I_ADD);
    end
  endtask

  task automatic test_ldur_wait();
    logic        rdy [9];
    logic [2:0]  st  [9];
    logic [11:0] cv  [9];
    rdy = '{1, 1, 1, 0, 0, 0, 1, 1, 0};
    st  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    cv  = '{12'hA80, 12'h000, 12'h010, 12'h190, 12'h190, 12'h190, 12'h190, 12'h003, 12'h080};
    mif.instruction = I_LDUR;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      mif.mem_ready = rdy[c]; #1;
      n_cmp++;
      if (state !== st[c] || ctl !== cv[c]) begin
        n_fail++;
        $display("FAIL ldur cyc%0d state=%0d ctl=%h, want %0d/%h", c + 1, state, ctl, st[c], cv[c]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins  [3];
    logic        zero [3];
    logic [11:0] ex   [3];
    logic        rdy  [4];
    logic [2:0]  st   [4];
    logic [11:0] cv   [4];
    ins  = '{I_CBZ, I_CBZ, I_B};
    zero = '{1, 0, 0};
    ex   = '{12'hC24, 12'h424, 12'hC00};
    rdy  = '{1, 1, 1, 0};
    st   = '{3'd0, 3'd1, 3'd2, 3'd0};
    for (int k = 0; k < 3; k++) begin
      cv = '{12'hA80, 12'h000, ex[k], 12'h080};
      mif.instruction = ins[k]; alu_zero = zero[k];
      apply_reset();
      for (int c = 0; c < 4; c++) begin
        mif.mem_ready = rdy[c]; #1;
        n_cmp++;
        if (state !== st[c] || ctl !== cv[c]) begin
          n_fail++;
          $display("FAIL branch%0d cyc%0d state=%0d ctl=%h, want %0d/%h", k, c + 1, state, ctl, st[c], cv[c]);
        end
        @(posedge clk); #1;
      end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [9];
    logic        rdy [9];
    logic [2:0]  st  [9];
    logic [11:0] cv  [9];
    ins = '{I_ADD, I_ADD, I_ADD, I_ADD, I_STUR, I_STUR, I_STUR, I_STUR, I_STUR};
    rdy = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    st  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    cv  = '{12'hA80, 12'h000, 12'h008, 12'h002, 12'hA80, 12'h000, 12'h030, 12'h170, 12'h080};
    mif.instruction = I_ADD;
    apply_reset();
    for (int c = 0; c < 9; c++) begin
      mif.instruction = ins[c]; mif.mem_ready = rdy[c]; #1;
      n_cmp++;
      if (state !== st[c] || ctl !== cv[c]) begin
        n_fail++;
        $display("FAIL b2b cyc%0d state=%0d ctl=%h, want %0d/%h", c + 1, state, ctl, st[c], cv[c]);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ir !== I_STUR) begin
      n_fail++;
      $display("FAIL b2b_ir ir=%h, want %h", ir, I_STUR);
    end
  endtask

  task automatic test_illegal();
    mif.instruction = 32'h0000_0000; alu_zero = 1'b1;
    apply_reset();
    mif.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Tempt the sequencer with a legal fetch while faulted; nothing may move.
    mif.instruction = I_ADD;
    for (int c = 0; c < 22; c++) begin
      #1;
      n_cmp++;
      if (state !== 3'd7 || fault !== 1'b1 || ctl !== 12'h000 || ir !== 32'h0) begin
        n_fail++;
        $display("FAIL illegal cyc%0d state=%0d fault=%b ctl=%h ir=%h, want 7/1/000/0", c, state, fault, ctl, ir);
      end
      @(posedge clk); #1;
    end
    mif.mem_ready = 1'b0;
    apply_reset();
    #1;
    n_cmp++;
    if (state !== 3'd0 || fault !== 1'b0 || ctl !== 12'h080) begin
      n_fail++;
      $display("FAIL illegal_recover state=%0d fault=%b ctl=%h, want 0/0/080", state, fault, ctl);
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_timeout();
    mif.instruction = I_ADD;
    for (int k = 0; k < 2; k++) begin
      mif.mem_ready = 1'b0;
      apply_reset();
      for (int c = 1; c <= 15; c++) begin
        mif.mem_ready = (k == 1 && c == 15);
        #1;
        n_cmp++;
        if (state !== 3'd0 || fault !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout%0d cyc%0d state=%0d fault=%b, want 0/0", k, c, state, fault);
        end
        @(posedge clk); #1;
      end
      mif.mem_ready = 1'b0; #1;
      n_cmp++;
      if (k == 0 && (state !== 3'd7 || fault !== 1'b1 || ctl !== 12'h000)) begin
        n_fail++;
        $display("FAIL fetch_timeout state=%0d fault=%b ctl=%h, want 7/1/000", state, fault, ctl);
      end else if (k == 1 && (state !== 3'd1 || fault !== 1'b0 || ir !== I_ADD)) begin
        n_fail++;
        $display("FAIL ready_at_limit state=%0d fault=%b ir=%h, want 1/0/%h", state, fault, ir, I_ADD);
      end
    end
    // MEM-phase timeout: LDUR whose data never arrives
    mif.instruction = I_LDUR; mif.mem_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    mif.mem_ready = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      n_cmp++;
      if (state !== 3'd3 || ctl !== 12'h190) begin
        n_fail++;
        $display("FAIL mem_wait cyc%0d state=%0d ctl=%h, want 3/190", c, state, ctl);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (state !== 3'd7 || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL mem_timeout state=%0d fault=%b, want 7/1", state, fault);
    end
  endtask

  task automatic test_reset_midwrite();
    mif.instruction = I_STUR; mif.mem_ready = 1'b1;
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    mif.mem_ready = 1'b0;
    @(posedge clk); #1;
    #1;
    n_cmp++;
    if (state !== 3'd3 || mif.control_memwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL stur_wait2 state=%0d memwrite=%b, want 3/1", state, mif.control_memwrite);
    end
    rst = 1'b1; #1;
    n_cmp++;
    if (mif.control_memwrite !== 1'b0 || ctl !== 12'h000 || state !== 3'd0 || ir !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drop memwrite=%b ctl=%h state=%0d ir=%h, want 0/000/0/0",
               mif.control_memwrite, ctl, state, ir);
    end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    n_cmp++;
    if (state !== 3'd0 || ir !== 32'h0 || fault !== 1'b0 || ctl !== 12'h080) begin
      n_fail++;
      $display("FAIL after_release state=%0d ir=%h fault=%b ctl=%h, want 0/0/0/080", state, ir, fault, ctl);
    end
  endtask

  initial begin
    rst = 1'b1; alu_zero = 1'b0;
    mif.instruction = 32'h0; mif.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_ldur_wait();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
